// File: rtl/dds_pkg.sv
// Shared types and reset defaults for the DDS voice bank.
// Waveform codes, per-voice config bundle and scan FSM states.
package dds_pkg;

   localparam logic [2:0] FORM_SAW   = 3'b000;
   localparam logic [2:0] FORM_PULSE = 3'b001;
   localparam logic [2:0] FORM_TRI   = 3'b010;

   localparam logic [7:0] RST_NOTE = 8'd69;
   localparam logic [2:0] RST_FORM = FORM_TRI;
   localparam logic [6:0] RST_PW   = 7'd64;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_ACC,
      ST_DONE
   } dds_state_e;

   typedef struct packed {
      logic [7:0] note;
      logic [2:0] form;
      logic [6:0] pw;
      logic       gate;
   } voice_cfg_t;

   localparam voice_cfg_t RST_CFG = '{
      note: RST_NOTE,
      form: RST_FORM,
      pw:   RST_PW,
      gate: 1'b0
   };

   // Notes above the MIDI range behave as the top note.
   function automatic logic [7:0] clamp_note(input logic [7:0] n);
      return n[7] ? 8'd127 : n;
   endfunction

endpackage

// File: rtl/dds_note_lut.sv
// MIDI note to phase increment, one register stage.
// Top-octave table built at elaboration; lower octaves by right shift.
module dds_note_lut
   import dds_pkg::*;
#(
   parameter int PHASE_W    = 32,
   parameter int SAMPLE_DIV = 1024,
   parameter int F_CLK_HZ   = 50_000_000
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic [7:0]         note,
   output logic [PHASE_W-1:0] inc
);

   logic [PHASE_W-1:0] base [16];

   // Notes 120..131: 440 Hz * 2^((n-69)/12), scaled to one sample period.
   for (genvar s = 0; s < 12; s++) begin : g_base
      localparam real FREQ =
         440.0 * 2.0 ** ((51.0 + s) / 12.0);
      localparam real INC_R =
         FREQ * (2.0 ** PHASE_W) * SAMPLE_DIV / F_CLK_HZ;
      localparam longint INC_I = longint'(INC_R);
      localparam longint HALF = longint'(1) << (PHASE_W - 1);
      if (s == 11 && INC_I >= HALF) begin : g_too_fast
         $error("dds_note_lut: top note increment too large");
      end
      assign base[s] = INC_I[PHASE_W-1:0];
   end

   for (genvar s = 12; s < 16; s++) begin : g_pad
      assign base[s] = '0;
   end

   logic [7:0]         note_c;
   logic [3:0]         semi;
   logic [3:0]         oct;
   logic [PHASE_W-1:0] inc_d;
   logic [PHASE_W-1:0] inc_q;

   // Split the clamped note into semitone and octave, shift the base.
   always_comb begin
      note_c = clamp_note(note);
      semi   = 4'(note_c % 8'd12);
      oct    = 4'(note_c / 8'd12);
      inc_d  = base[semi] >> (4'd10 - oct);
   end

   // Register the increment so it is stable through the ACC cycle.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         inc_q <= '0;
      end else begin
         inc_q <= inc_d;
      end
   end

   assign inc = inc_q;

endmodule

// File: rtl/dds_voice_bank.sv
// Time-multiplexed polyphonic DDS bank with one shared phase engine.
// Each sample period scans all voices and emits a summed sample.
module dds_voice_bank
   import dds_pkg::*;
#(
   parameter int VOICES     = 4,
   parameter int PHASE_W    = 32,
   parameter int OUT_W      = 16,
   parameter int SAMPLE_DIV = 1024,
   parameter int F_CLK_HZ   = 50_000_000,
   localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1,
   localparam int MW = OUT_W + $clog2(VOICES)
) (
   input  logic                 CLK,
   input  logic                 RESET_N,
   input  logic                 cfg_we,
   input  logic [VW-1:0]        cfg_voice,
   input  logic [7:0]           cfg_note,
   input  logic [2:0]           cfg_form,
   input  logic [6:0]           cfg_pw,
   input  logic                 cfg_gate,
   output logic                 sample_strobe,
   output logic signed [MW-1:0] mix_out
);

   localparam int CW = $clog2(SAMPLE_DIV);

   localparam logic [OUT_W-1:0] POS =
      {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] NEG =
      {1'b1, {(OUT_W-2){1'b0}}, 1'b1};

   if (VOICES < 1 || OUT_W < 8 || OUT_W > PHASE_W ||
       SAMPLE_DIV < 2 * VOICES + 2) begin : g_bad_cfg
      $error("dds_voice_bank: illegal parameter set");
   end

   logic [CW-1:0] div_q, div_d;
   logic          tc;

   voice_cfg_t stg_q [VOICES];
   voice_cfg_t stg_d [VOICES];
   voice_cfg_t act_q [VOICES];
   voice_cfg_t act_d [VOICES];
   voice_cfg_t wr_cfg;

   logic [PHASE_W-1:0] phase_q [VOICES];
   logic [PHASE_W-1:0] phase_d [VOICES];

   dds_state_e state_q, state_d;
   logic [VW-1:0]        vidx_q, vidx_d;
   logic signed [MW-1:0] mix_acc_q, mix_acc_d;
   logic signed [MW-1:0] mix_out_q, mix_out_d;
   logic                 strobe_q, strobe_d;

   voice_cfg_t           cur;
   logic [PHASE_W-1:0]   cur_phase;
   logic [PHASE_W-1:0]   inc;
   logic [OUT_W-1:0]     p;
   logic [OUT_W-1:0]     p2;
   logic [OUT_W-1:0]     tv;
   logic signed [OUT_W-1:0] smp_s;
   logic signed [MW-1:0] smp_x;
   logic signed [MW-1:0] mix_add;
   logic                 last;

   // Sample-period divider; TC starts a scan.
   always_comb begin
      tc    = (div_q == CW'(SAMPLE_DIV - 1));
      div_d = tc ? '0 : div_q + CW'(1);
   end

   // Staging takes writes; active reloads at TC with the write bypassed.
   always_comb begin
      wr_cfg = '{
         note: cfg_note,
         form: cfg_form,
         pw:   cfg_pw,
         gate: cfg_gate
      };
      stg_d = stg_q;
      for (int v = 0; v < VOICES; v++) begin
         if (cfg_we && cfg_voice == VW'(v)) begin
            stg_d[v] = wr_cfg;
         end
      end
      act_d = act_q;
      if (tc) begin
         act_d = stg_d;
      end
   end

   dds_note_lut #(
      .PHASE_W    (PHASE_W),
      .SAMPLE_DIV (SAMPLE_DIV),
      .F_CLK_HZ   (F_CLK_HZ)
   ) u_lut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .note    (act_q[vidx_q].note),
      .inc     (inc)
   );

   // Waveform of the voice under scan, taken from its old phase.
   always_comb begin
      cur       = act_q[vidx_q];
      cur_phase = phase_q[vidx_q];
      p         = cur_phase[PHASE_W-1 -: OUT_W];
      p2        = p << 1;
      tv        = p[OUT_W-1] ? ~p2 : p2;
      smp_s     = '0;
      unique case (cur.form)
         FORM_SAW:   smp_s = {~p[OUT_W-1], p[OUT_W-2:0]};
         FORM_PULSE: smp_s =
            (cur_phase[PHASE_W-1 -: 7] < cur.pw) ? POS : NEG;
         FORM_TRI:   smp_s = {~tv[OUT_W-1], tv[OUT_W-2:0]};
         default:    smp_s = '0;
      endcase
      if (!cur.gate) begin
         smp_s = '0;
      end
      smp_x   = MW'(smp_s);
      mix_add = mix_acc_q + smp_x;
      last    = (vidx_q == VW'(VOICES - 1));
   end

   // Scan FSM: LOOKUP/ACC per voice, then publish the mix.
   always_comb begin
      state_d   = state_q;
      vidx_d    = vidx_q;
      mix_acc_d = mix_acc_q;
      mix_out_d = mix_out_q;
      strobe_d  = 1'b0;
      phase_d   = phase_q;
      unique case (state_q)
         ST_IDLE: begin
            if (tc) begin
               state_d   = ST_LOOKUP;
               vidx_d    = '0;
               mix_acc_d = '0;
            end
         end
         ST_LOOKUP: begin
            state_d = ST_ACC;
         end
         ST_ACC: begin
            mix_acc_d = mix_add;
            phase_d[vidx_q] =
               cur.gate ? cur_phase + inc : '0;
            if (last) begin
               state_d   = ST_DONE;
               mix_out_d = mix_add;
               strobe_d  = 1'b1;
            end else begin
               state_d = ST_LOOKUP;
               vidx_d  = vidx_q + VW'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Divider and voice configuration registers.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         div_q <= '0;
         for (int v = 0; v < VOICES; v++) begin
            stg_q[v] <= RST_CFG;
            act_q[v] <= RST_CFG;
         end
      end else begin
         div_q <= div_d;
         stg_q <= stg_d;
         act_q <= act_d;
      end
   end

   // Scan state, phases and registered outputs.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= ST_IDLE;
         vidx_q    <= '0;
         mix_acc_q <= '0;
         mix_out_q <= '0;
         strobe_q  <= 1'b0;
         for (int v = 0; v < VOICES; v++) begin
            phase_q[v] <= '0;
         end
      end else begin
         state_q   <= state_d;
         vidx_q    <= vidx_d;
         mix_acc_q <= mix_acc_d;
         mix_out_q <= mix_out_d;
         strobe_q  <= strobe_d;
         phase_q   <= phase_d;
      end
   end

   assign sample_strobe = strobe_q;
   assign mix_out       = mix_out_q;

endmodule

// File: doc/dds_voice_bank.md
# dds_voice_bank

Parametrised, time-multiplexed polyphonic DDS oscillator bank for the synth datapath. It generalises the single-voice note/form/pulse-width oscillator to VOICES independent voices, each with a gate. One shared phase-update engine scans all voices once per sample period and emits a signed mixed sample with a one-cycle strobe. It sits between the note/control front end (MIDI decode) and the output DAC/PWM stage.

## Interface
- VOICES, 4, number of voices (>=1)
- PHASE_W, 32, phase accumulator width
- OUT_W, 16, per-voice signed sample width (>=8)
- SAMPLE_DIV, 1024, CLK cycles per sample period; must be >= 2*VOICES+2
- F_CLK_HZ, 50_000_000, clock frequency used to build the increment table
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous, active-low reset
- cfg_we  in  1  write strobe for one voice's staging config
- cfg_voice  in  max(1,$clog2(VOICES))  voice index
- cfg_note  in  8  MIDI note; values >127 clamp to 127
- cfg_form  in  3  000 saw, 001 pulse, 010 triangle, others silence
- cfg_pw  in  7  pulse threshold (0..127)
- cfg_gate  in  1  voice enable
- sample_strobe  out  1  one-cycle pulse when mix_out updates
- mix_out  out  OUT_W+$clog2(VOICES)  signed sum of voice samples

## Operation
- Per voice: staging regs (written by cfg_we), active regs (used by scan), phase accumulator.
- Divider counts 0..SAMPLE_DIV-1, wraps. At terminal count (TC): active <= staging for all voices; a cfg_we in the TC cycle is bypassed into active (write wins). Writes at any other time affect only the next scan.
- FSM: IDLE -> (TC) LOOKUP(v) -> ACC(v) -> LOOKUP(v+1) ... ACC(VOICES-1) -> DONE -> IDLE.
- LOOKUP: registered increment for the voice's note from the note LUT.
- ACC: sample from current (old) phase, add to mix accumulator; then phase <= phase + inc mod 2^PHASE_W. If gate=0: sample 0, phase <= 0, so the next gate-on starts at phase 0.
- Waveforms, p = phase[PHASE_W-1 -: OUT_W]:
  - saw = p with MSB inverted (phase 0 -> -2^(OUT_W-1))
  - pulse = phase[PHASE_W-1 -: 7] < pw ? +(2^(OUT_W-1)-1) : -(2^(OUT_W-1)-1); pw=0 gives constant negative
  - triangle: t = p[OUT_W-1] ? ~(p<<1) : (p<<1), MSB inverted
  - other codes: 0
- Note LUT: 12 base increments for notes 120..131, BASE[s] = round(440*2^((120+s-69)/12) * 2^PHASE_W * SAMPLE_DIV / F_CLK_HZ), computed at elaboration. inc(n) = BASE[n%12] >> (10 - n/12). Elaboration must fail if BASE[11] >= 2^(PHASE_W-1).
- Mix: full-width signed sum, no saturation.

## Timing
- Reset values: divider 0, FSM IDLE, phases 0, mix_out 0, sample_strobe 0; staging/active note 69, form 010, pw 64, gate 0.
- First TC is cycle 1023 after reset release (default); sample_strobe rises 2*VOICES+1 cycles after TC (9 by default) and lasts exactly one cycle, together with the mix_out update. mix_out holds between strobes.
- RESET_N asserted mid-scan: all state clears immediately, no strobe, partial mix discarded.
- Phase wraps silently modulo 2^PHASE_W.

## Structure
- Package dds_pkg: form encodings, reset-default note/form/pw, FSM state enum.
- Sub-module dds_note_lut: clamped note in, registered increment out, elaboration-time BASE table.

## Test plan
- Reset: hold RESET_N low, release -> outputs 0; strobe 9 cycles after cycle 1023, mix_out 0 (all gates off).
- Voice0 gate=1, note 69, saw -> inc 38702809; first sample -32768, second -32178 (p=590).
- Voice0 pulse, pw 64, note 69 -> first sample +32767; sign flips when phase[31:25] reaches 64; pw=0 -> constant -32767.
- All 4 voices saw, note 69, gate on -> first mix_out -131072 (18-bit), second -128712.
- Write voice2 note 60 mid-scan -> used only from next scan; same write in TC cycle -> used this scan; note 200 -> behaves as 127.
- Assert RESET_N between LOOKUP and ACC -> no strobe, phases 0, mix_out 0; normal operation resumes after release.
